// File: rtl/accum_stim.sv
// accum_stim: burst stimulus generator and self-checker for an external accumulator.
//
// On an accepted start the block issues `count` pseudo-random beats (Galois LFSR,
// values folded into 0..LIMIT), tracks the expected accumulator total in `exp`,
// and compares the returned `acc` one cycle after each accumulator update.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - burst request, sampled only in IDLE
//   count    - beats in the burst, captured with start
//   seed     - LFSR seed, captured with start (zero is replaced by 1)
//   hold     - stalls beat issue while high
//   acc      - accumulator result returned by the accumulator
//   set_val  - registered beat strobe to the accumulator
//   val      - beat value, bits [31:7] always zero
//   busy     - high in RUN and DRAIN
//   done     - one-cycle end-of-burst pulse
//   exp      - expected accumulator value
//   err      - sticky mismatch flag, cleared by the next accepted start
//   err_cnt  - saturating mismatch count, cleared by the next accepted start
module accum_stim #(
    parameter int unsigned LIMIT = 100,
    parameter logic [31:0] POLY  = 32'h80200003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  count,
    input  logic [31:0] seed,
    input  logic        hold,
    input  logic [63:0] acc,
    output logic        set_val,
    output logic [31:0] val,
    output logic        busy,
    output logic        done,
    output logic [63:0] exp,
    output logic        err,
    output logic [15:0] err_cnt
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [6:0] LimP1 = 7'(LIMIT + 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [6:0]  val_q, val_d;
    logic        set_val_q, set_val_d;
    logic [63:0] exp_q, exp_d;
    logic        chk_q, chk_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [31:0] lfsr_nxt;
    logic [6:0]  r;
    logic [6:0]  val_nxt;

    always_comb begin
        lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'd0);
        r        = lfsr_nxt[6:0];
        // Fold 0..127 into 0..LIMIT; LIMIT >= 63 makes a single subtraction enough.
        if ({25'd0, r} <= LIMIT) begin
            val_nxt = r;
        end else begin
            val_nxt = r - LimP1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        lfsr_d    = lfsr_q;
        val_d     = val_q;
        set_val_d = 1'b0;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        // The accumulator absorbs a beat on the edge after set_val; exp follows on
        // that same edge, and the compare is taken one edge later.
        exp_d = set_val_q ? exp_q + {57'd0, val_q} : exp_q;
        chk_d = set_val_q;

        if (chk_q && (acc != exp_q)) begin
            err_d = 1'b1;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d     = count;
                    lfsr_d    = (seed == 32'd0) ? 32'd1 : seed;
                    exp_d     = acc;
                    chk_d     = 1'b0;
                    err_d     = 1'b0;
                    err_cnt_d = 16'd0;
                    state_d   = (count == 8'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (!hold) begin
                    lfsr_d    = lfsr_nxt;
                    val_d     = val_nxt;
                    set_val_d = 1'b1;
                    rem_d     = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_q     <= 8'd0;
            lfsr_q    <= 32'd1;
            val_q     <= 7'd0;
            set_val_q <= 1'b0;
            exp_q     <= 64'd0;
            chk_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            lfsr_q    <= lfsr_d;
            val_q     <= val_d;
            set_val_q <= set_val_d;
            exp_q     <= exp_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign set_val = set_val_q;
    assign val     = {25'd0, val_q};
    assign busy    = (state_q == StRun) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign exp     = exp_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_accum_stim.sv
// Self-checking bench for accum_stim: an accumulator model, a value scoreboard fed
// from an independent LFSR model, and directed burst scenarios.
module tb_accum_stim;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  count = 8'd0;
    logic [31:0] seed = 32'd0;
    logic        hold = 1'b0;
    logic [63:0] acc_m;
    logic        set_val;
    logic [31:0] val;
    logic        busy;
    logic        done;
    logic [63:0] exp_o;
    logic        err;
    logic [15:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb_q[$];
    logic [31:0] sb_e;
    int          nbeats = 0;
    logic        fault_en = 1'b0;
    logic        acc_load = 1'b1;
    logic [63:0] acc_load_val = 64'd0;
    logic [63:0] base_m;
    logic [63:0] sum_m;

    always #5 clk = ~clk;

    accum_stim dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .count   (count),
        .seed    (seed),
        .hold    (hold),
        .acc     (acc_m),
        .set_val (set_val),
        .val     (val),
        .busy    (busy),
        .done    (done),
        .exp     (exp_o),
        .err     (err),
        .err_cnt (err_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    // Accumulator model; the fault adds one extra on the second beat of a burst.
    always @(posedge clk) begin
        if (acc_load) begin
            acc_m <= acc_load_val;
        end else if (set_val) begin
            acc_m <= acc_m + {32'd0, val} + ((fault_en && nbeats == 2) ? 64'd1 : 64'd0);
        end
    end

    // Scoreboard consumer: every beat must match the next expected value.
    always @(negedge clk) begin
        if (rst_n && set_val) begin
            nbeats++;
            if (sb_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check("val", {32'd0, val}, {32'd0, sb_e});
            end
        end
    end

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
    endfunction

    task automatic start_burst(input logic [7:0] c, input logic [31:0] sd);
        logic [31:0] s;
        logic [6:0]  rr;
        logic [31:0] v;
        s     = (sd == 32'd0) ? 32'd1 : sd;
        sum_m = 64'd0;
        for (int i = 0; i < int'(c); i++) begin
            s  = lfsr_next(s);
            rr = s[6:0];
            v  = (rr <= 7'd100) ? {25'd0, rr} : {25'd0, rr - 7'd101};
            sb_q.push_back(v);
            sum_m = sum_m + {32'd0, v};
        end
        @(negedge clk);
        start  = 1'b1;
        count  = c;
        seed   = sd;
        nbeats = 0;
        base_m = acc_m;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, {63'd0, c != 8'd0});
        check("done_after_start", {63'd0, done}, {63'd0, c == 8'd0});
    endtask

    task automatic wait_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("busy_after_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_set_val", {63'd0, set_val}, 64'd0);
        check("rst_val", {32'd0, val}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_exp", exp_o, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_err_cnt", {48'd0, err_cnt}, 64'd0);
        rst_n    = 1'b1;
        acc_load = 1'b0;

        // Basic burst, with a stray start mid-burst that must be ignored.
        start_burst(8'd3, 32'd1);
        start = 1'b1;
        count = 8'd50;
        @(negedge clk);
        start = 1'b0;
        wait_done(20);
        check("basic_exp", exp_o, 64'd6);
        check("basic_exp_model", exp_o, base_m + sum_m);
        check("basic_err", {63'd0, err}, 64'd0);
        check("basic_beats", nbeats, 3);

        // Zero count: straight to DONE, no beats.
        start_burst(8'd0, 32'd77);
        wait_done(5);
        check("zero_beats", nbeats, 0);
        check("zero_err_cnt", {48'd0, err_cnt}, 64'd0);
        check("zero_exp", exp_o, base_m);

        // Hold gap of two cycles after the first beat.
        start_burst(8'd3, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (set_val) break;
        end
        hold = 1'b1;
        @(negedge clk);
        check("hold_gap0", {63'd0, set_val}, 64'd0);
        @(negedge clk);
        check("hold_gap1", {63'd0, set_val}, 64'd0);
        hold = 1'b0;
        wait_done(20);
        check("hold_beats", nbeats, 3);
        check("hold_exp", exp_o, base_m + 64'd6);
        check("hold_err", {63'd0, err}, 64'd0);

        // Faulty accumulator on the second beat.
        fault_en = 1'b1;
        start_burst(8'd2, 32'd1);
        wait_done(20);
        fault_en = 1'b0;
        check("fault_err", {63'd0, err}, 64'd1);
        check("fault_err_cnt", {48'd0, err_cnt}, 64'd1);
        check("fault_exp", exp_o, base_m + 64'd5);
        start_burst(8'd1, 32'd1);
        check("fault_clr_err", {63'd0, err}, 64'd0);
        check("fault_clr_cnt", {48'd0, err_cnt}, 64'd0);
        wait_done(20);
        check("fault_after_err", {63'd0, err}, 64'd0);

        // Non-zero base.
        acc_load_val = 64'd1000;
        acc_load     = 1'b1;
        @(negedge clk);
        acc_load = 1'b0;
        start_burst(8'd3, 32'd1);
        wait_done(20);
        check("base_exp", exp_o, 64'd1006);
        check("base_err", {63'd0, err}, 64'd0);

        // Wrap-around of exp is not an error.
        acc_load_val = 64'hFFFF_FFFF_FFFF_FFFE;
        acc_load     = 1'b1;
        @(negedge clk);
        acc_load = 1'b0;
        start_burst(8'd3, 32'd1);
        wait_done(20);
        check("wrap_exp", exp_o, 64'd4);
        check("wrap_err", {63'd0, err}, 64'd0);

        // Asynchronous reset mid-burst, then a zero seed.
        start_burst(8'd10, 32'd5);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_set_val", {63'd0, set_val}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        sb_q.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_done", {63'd0, done}, 64'd0);
        end
        rst_n = 1'b1;
        start_burst(8'd3, 32'd0);
        wait_done(20);
        check("seed0_beats", nbeats, 3);
        check("seed0_exp", exp_o, base_m + 64'd6);
        check("seed0_err", {63'd0, err}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
